// File: rtl/rprelu_param_ctrl_if.sv
// Bus bundle for the RPReLU parameter controller: host config stream, BN valid/mode
// inputs, parameter banks and status outputs.
interface rprelu_param_ctrl_if #(
  parameter int unsigned PARA_WIDTH  = 16,
  parameter int unsigned CHANNEL_NUM = 128
);
  logic                                   cfg_start;
  logic                                   cfg_valid;
  logic [PARA_WIDTH-1:0]                  cfg_data;
  logic                                   cfg_ready;
  logic                                   data_in_valid;
  logic                                   mode_in;
  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] rprelu_beta;
  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] rprelu_gamma;
  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] rprelu_zeta;
  logic                                   dp_valid;
  logic                                   busy;
  logic                                   done;
  logic                                   err;

  modport master (
    output cfg_start, cfg_valid, cfg_data, data_in_valid, mode_in,
    input  cfg_ready, rprelu_beta, rprelu_gamma, rprelu_zeta, dp_valid, busy, done, err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, data_in_valid, mode_in,
    output cfg_ready, rprelu_beta, rprelu_gamma, rprelu_zeta, dp_valid, busy, done, err
  );
endinterface

// File: rtl/rprelu_param_ctrl.sv
// Loads per-channel beta/gamma/zeta banks from a serial word stream and gates the BN valid
// until the banks are complete. Define RPRELU_PARAM_CHECKSUM_EN for a trailing checksum word.
module rprelu_param_ctrl #(
  parameter int unsigned PARA_WIDTH  = 16,
  parameter int unsigned CHANNEL_NUM = 128
) (
  input  logic               clk,
  input  logic               rstn,
  rprelu_param_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(CHANNEL_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNEL_NUM - 1);

  typedef logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] bank_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_BETA,
    LD_GAMMA,
    LD_ZETA,
`ifdef RPRELU_PARAM_CHECKSUM_EN
    LD_CSUM,
`endif
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bank_t            beta_q, beta_d, gamma_q, gamma_d, zeta_q, zeta_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept, last;
`ifdef RPRELU_PARAM_CHECKSUM_EN
  logic [PARA_WIDTH-1:0] sum_q, sum_d;
`endif

  function automatic logic is_load(input state_e s);
    return (s == LD_BETA) || (s == LD_GAMMA) || (s == LD_ZETA)
`ifdef RPRELU_PARAM_CHECKSUM_EN
           || (s == LD_CSUM)
`endif
           ;
  endfunction

  // A restart pulse wins over a word presented in the same cycle.
  assign accept = bus.cfg_valid && cfg_ready_q && !bus.cfg_start;
  assign last   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beta_d  = beta_q;
    gamma_d = gamma_q;
    zeta_d  = zeta_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef RPRELU_PARAM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (bus.cfg_start) begin
      state_d = LD_BETA;
      cnt_d   = '0;
      err_d   = 1'b0;
`ifdef RPRELU_PARAM_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      if (is_load(state_q) && bus.data_in_valid && bus.mode_in) err_d = 1'b1;
      if (accept) begin
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
          LD_BETA: begin
            beta_d[cnt_q] = bus.cfg_data;
            if (last) state_d = LD_GAMMA;
          end
          LD_GAMMA: begin
            gamma_d[cnt_q] = bus.cfg_data;
            if (last) state_d = LD_ZETA;
          end
          LD_ZETA: begin
            zeta_d[cnt_q] = bus.cfg_data;
            if (last) begin
`ifdef RPRELU_PARAM_CHECKSUM_EN
              state_d = LD_CSUM;
`else
              state_d = RUN;
              done_d  = 1'b1;
`endif
            end
          end
`ifdef RPRELU_PARAM_CHECKSUM_EN
          LD_CSUM: begin
            cnt_d = '0;
            if (bus.cfg_data == sum_q) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
`endif
          default: ;
        endcase
`ifdef RPRELU_PARAM_CHECKSUM_EN
        if (state_q != LD_CSUM) sum_d = sum_q + bus.cfg_data;
`endif
      end
    end
    // Ready drops for the single cycle after a bank boundary.
    busy_d      = is_load(state_d);
    cfg_ready_d = busy_d && !(accept && last);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beta_q      <= '0;
      gamma_q     <= '0;
      zeta_q      <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef RPRELU_PARAM_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beta_q      <= beta_d;
      gamma_q     <= gamma_d;
      zeta_q      <= zeta_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef RPRELU_PARAM_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rprelu_beta  = beta_q;
  assign bus.rprelu_gamma = gamma_q;
  assign bus.rprelu_zeta  = zeta_q;
  assign bus.dp_valid     = bus.data_in_valid && bus.mode_in && (state_q == RUN);
endmodule

// File: tb/tb_rprelu_param_ctrl.sv
// Randomised self-checking bench for rprelu_param_ctrl against a flat-stream bank model.
module tb_rprelu_param_ctrl;
  localparam int unsigned PW = 16;
  localparam int unsigned CH = 128;
`ifdef RPRELU_PARAM_CHECKSUM_EN
  localparam int NW   = 3 * CH + 1;
  localparam int NBND = 3;
`else
  localparam int NW   = 3 * CH;
  localparam int NBND = 2;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [PW-1:0] mdl [3][CH];
  logic [PW-1:0] stream [$];

  always #5 clk = ~clk;

  rprelu_param_ctrl_if #(.PARA_WIDTH(PW), .CHANNEL_NUM(CH)) bus ();
  rprelu_param_ctrl #(.PARA_WIDTH(PW), .CHANNEL_NUM(CH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b0;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Stream order is beta[0..CH-1], gamma[...], zeta[...], then the checksum if enabled.
  task automatic build_stream(input int kind);
    int v;
    logic [PW-1:0] s;
    stream.delete();
    s = '0;
    for (int k = 0; k < 3 * int'(CH); k++) begin
      int b = k / int'(CH);
      int i = k % int'(CH);
      if (kind == 0) v = (b == 0) ? i : ((b == 1) ? -i : 2 * i);
      else           v = int'($urandom);
      stream.push_back(PW'(v));
      s = s + PW'(v);
    end
`ifdef RPRELU_PARAM_CHECKSUM_EN
    stream.push_back(s);
`endif
  endtask

  function automatic void mdl_apply(input int n);
    for (int k = 0; k < n && k < 3 * int'(CH); k++)
      mdl[k / int'(CH)][k % int'(CH)] = stream[k];
  endfunction

  function automatic logic [PW-1:0] dut_bank(input int b, input int i);
    if (b == 0) return bus.rprelu_beta[i];
    if (b == 1) return bus.rprelu_gamma[i];
    return bus.rprelu_zeta[i];
  endfunction

  // Presents stream[first..last_excl-1]; reports accepted words, done pulses, done lag, ready gaps.
  task automatic feed(input int first, input int last_excl, input int vpct,
                      output int n_acc, output int n_done, output int lag, output int rdy_low);
    int idx, cyc, acc_cyc, done_cyc;
    bit seen_rdy, acc;
    idx = first; cyc = 0; acc_cyc = -100; done_cyc = -1000; seen_rdy = 0;
    n_acc = 0; n_done = 0; rdy_low = 0;
    while (idx < last_excl && cyc < 20000) begin
      if (bus.done) begin n_done++; done_cyc = cyc; end
      bus.cfg_valid = ($urandom_range(0, 99) < vpct);
      bus.cfg_data  = stream[idx];
      if (bus.cfg_ready) seen_rdy = 1'b1;
      else if (seen_rdy) rdy_low++;
      acc = bus.cfg_valid && bus.cfg_ready;
      tick();
      if (acc) begin idx++; n_acc++; acc_cyc = cyc; end
      cyc++;
    end
    bus.cfg_valid = 1'b0;
    repeat (3) begin
      if (bus.done) begin n_done++; done_cyc = cyc; end
      tick();
      cyc++;
    end
    lag = done_cyc - acc_cyc;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = '0;
    bus.data_in_valid = 0; bus.mode_in = 0;
    for (int b = 0; b < 3; b++) for (int i = 0; i < int'(CH); i++) mdl[b][i] = '0;
    repeat (3) tick();
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.cfg_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    checks++; if (bus.rprelu_zeta[CH-1] !== '0) begin errors++; $display("FAIL reset_bank got %h exp 0", bus.rprelu_zeta[CH-1]); end
    rstn = 1'b1;
    tick();
    bus.data_in_valid = 1; bus.mode_in = 1;
    #1;
    checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL idle_dp_valid got %b exp 0", bus.dp_valid); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL idle_drop_err got %b exp 0", bus.err); end
    bus.data_in_valid = 0; bus.mode_in = 0;
  endtask

  task automatic test_reset_midload();
    int na, nd, lg, rl;
    build_stream(0);
    pulse_start();
    feed(0, 10, 100, na, nd, lg, rl);
    checks++; if (bus.rprelu_beta[9] !== PW'(9)) begin errors++; $display("FAIL midload_beta9 got %h exp 0009", bus.rprelu_beta[9]); end
    #2 rstn = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) for (int i = 0; i < int'(CH); i++) mdl[b][i] = '0;
    checks++; if (bus.rprelu_beta !== '0) begin errors++; $display("FAIL midload_beta_clear got nonzero exp 0"); end
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL midload_ready got %b exp 0", bus.cfg_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midload_busy got %b exp 0", bus.busy); end
    tick();
    rstn = 1'b1;
    bus.cfg_valid = 1'b1;
    repeat (3) tick();
    bus.cfg_valid = 1'b0;
    checks++; if (bus.cfg_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midload_idle ready/busy got %b/%b exp 0/0", bus.cfg_ready, bus.busy); end
    checks++; if (bus.rprelu_beta[0] !== '0 || bus.rprelu_beta[9] !== '0) begin errors++; $display("FAIL midload_ignored_valid bank got %h exp 0", bus.rprelu_beta[9]); end
  endtask

  task automatic check_load(input string nm, input int exp_done, input int na, input int nd,
                            input int lg, input int rl, input int exp_rl);
    checks++; if (na !== NW) begin errors++; $display("FAIL %s_accepted got %0d exp %0d", nm, na, NW); end
    checks++; if (nd !== exp_done) begin errors++; $display("FAIL %s_done_count got %0d exp %0d", nm, nd, exp_done); end
    if (exp_done == 1) begin
      checks++; if (lg !== 1) begin errors++; $display("FAIL %s_done_lag got %0d exp 1", nm, lg); end
    end
    checks++; if (rl !== exp_rl) begin errors++; $display("FAIL %s_ready_gaps got %0d exp %0d", nm, rl, exp_rl); end
    for (int b = 0; b < 3; b++) for (int i = 0; i < int'(CH); i++) begin
      checks++;
      if (dut_bank(b, i) !== mdl[b][i]) begin
        errors++; $display("FAIL %s_bank%0d[%0d] got %h exp %h", nm, b, i, dut_bank(b, i), mdl[b][i]);
      end
    end
  endtask

  task automatic test_full_load();
    int na, nd, lg, rl;
    logic dv, md;
    build_stream(0);
    pulse_start();
    feed(0, NW, 100, na, nd, lg, rl);
    mdl_apply(NW);
    check_load("full", 1, na, nd, lg, rl, NBND);
    checks++; if (bus.rprelu_gamma[CH-1] !== 16'hFF81) begin errors++; $display("FAIL full_gamma127 got %h exp ff81", bus.rprelu_gamma[CH-1]); end
    checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL full_status busy/err got %b/%b exp 0/0", bus.busy, bus.err); end
    for (int c = 0; c < 16; c++) begin
      dv = 1'($urandom); md = 1'($urandom);
      bus.data_in_valid = dv; bus.mode_in = md;
      bus.cfg_valid = 1'($urandom); bus.cfg_data = PW'($urandom);
      #1;
      checks++; if (bus.dp_valid !== (dv & md)) begin errors++; $display("FAIL run_dp_valid c%0d got %b exp %b", c, bus.dp_valid, dv & md); end
      tick();
    end
    bus.data_in_valid = 0; bus.mode_in = 0; bus.cfg_valid = 0;
    checks++; if (bus.rprelu_zeta !== dut.zeta_q || bus.rprelu_zeta[5] !== PW'(10)) begin errors++; $display("FAIL run_stable zeta5 got %h exp 000a", bus.rprelu_zeta[5]); end
    checks++; if (bus.done !== 1'b0 || bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL run_idle done/ready got %b/%b exp 0/0", bus.done, bus.cfg_ready); end
  endtask

  task automatic test_backpressure();
    int na, nd, lg, rl;
    build_stream(1);
    pulse_start();
    feed(0, NW, 50, na, nd, lg, rl);
    mdl_apply(NW);
    check_load("gaps", 1, na, nd, lg, rl, NBND);
  endtask

  task automatic test_overrun();
    int na, nd, lg, rl, na2;
    build_stream(1);
    pulse_start();
    feed(0, CH + 2, 100, na, nd, lg, rl);
    bus.data_in_valid = 1; bus.mode_in = 1;
    #1;
    checks++; if (bus.dp_valid !== 1'b0) begin errors++; $display("FAIL overrun_dp_valid got %b exp 0", bus.dp_valid); end
    tick();
    bus.data_in_valid = 0; bus.mode_in = 0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL overrun_err got %b exp 1", bus.err); end
    feed(CH + 2, NW, 100, na2, nd, lg, rl);
    mdl_apply(NW);
    check_load("overrun", 1, na + na2, nd, lg, rl, NBND - 1);
    bus.data_in_valid = 1; bus.mode_in = 1;
    #1;
    checks++; if (bus.dp_valid !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL overrun_run dp_valid/err got %b/%b exp 1/1", bus.dp_valid, bus.err); end
    tick();
    bus.data_in_valid = 0; bus.mode_in = 0;
    pulse_start();
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL overrun_clear err/busy got %b/%b exp 0/1", bus.err, bus.busy); end
  endtask

  task automatic test_restart();
    int na, nd, lg, rl;
    logic [PW-1:0] old_g5;
    build_stream(1);
    pulse_start();
    feed(0, CH + 5, 100, na, nd, lg, rl);
    old_g5 = mdl[1][5];
    mdl_apply(CH + 5);
    bus.cfg_valid = 1'b1; bus.cfg_data = ~old_g5; bus.cfg_start = 1'b1;
    tick();
    bus.cfg_valid = 1'b0; bus.cfg_start = 1'b0;
    checks++; if (bus.rprelu_gamma[5] !== old_g5) begin errors++; $display("FAIL restart_discard got %h exp %h", bus.rprelu_gamma[5], old_g5); end
    checks++; if (bus.rprelu_gamma[4] !== mdl[1][4]) begin errors++; $display("FAIL restart_partial got %h exp %h", bus.rprelu_gamma[4], mdl[1][4]); end
    checks++; if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL restart_state busy/ready got %b/%b exp 1/1", bus.busy, bus.cfg_ready); end
    build_stream(1);
    feed(0, NW, 70, na, nd, lg, rl);
    mdl_apply(NW);
    check_load("restart", 1, na, nd, lg, rl, NBND);
  endtask

`ifdef RPRELU_PARAM_CHECKSUM_EN
  task automatic test_checksum();
    int na, nd, lg, rl;
    build_stream(1);
    pulse_start();
    feed(0, NW, 100, na, nd, lg, rl);
    mdl_apply(NW);
    check_load("csum_ok", 1, na, nd, lg, rl, NBND);
    build_stream(1);
    stream[NW-1] = stream[NW-1] + PW'(1);
    pulse_start();
    feed(0, NW, 100, na, nd, lg, rl);
    mdl_apply(NW);
    check_load("csum_bad", 0, na, nd, lg, rl, NBND);
    bus.data_in_valid = 1; bus.mode_in = 1;
    #1;
    checks++; if (bus.err !== 1'b1 || bus.dp_valid !== 1'b0) begin errors++; $display("FAIL csum_bad err/dp_valid got %b/%b exp 1/0", bus.err, bus.dp_valid); end
    tick();
    bus.data_in_valid = 0; bus.mode_in = 0;
    checks++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL csum_bad_idle busy/ready got %b/%b exp 0/0", bus.busy, bus.cfg_ready); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_midload();
    test_full_load();
    test_backpressure();
    test_overrun();
    test_restart();
`ifdef RPRELU_PARAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
